// File: rtl/weight_load_ctrl.sv
// Sequences a flat parameter-word stream into the per-layer weight/bias RAMs
// and gates inference start until every RAM holds a complete parameter set.
module weight_load_ctrl #(
    parameter int MEM_WORD_SIZE     = 21,
    parameter int LAYER_SELECT_BITS = 2,
    parameter int RAM_SELECT_BITS   = 8,
    parameter int RAM_ADDRESS_BITS  = 9,
    parameter int L0_RAMS           = 256,
    parameter int L0_DEPTH          = 33,
    parameter int L1_RAMS           = 256,
    parameter int L1_DEPTH          = 257,
    parameter int L2_RAMS           = 4,
    parameter int L2_DEPTH          = 256,
    parameter int L3_RAMS           = 10,
    parameter int L3_DEPTH          = 257
) (
    input  logic                                                         clk_i,
    input  logic                                                         reset_i,
    input  logic                                                         load_i,
    input  logic                                                         net_busy_i,
    input  logic                                                         start_i,
    input  logic [MEM_WORD_SIZE-1:0]                                     data_i,
    input  logic                                                         valid_i,
    output logic                                                         ready_o,
    output logic                                                         w_en_o,
    output logic [MEM_WORD_SIZE-1:0]                                     w_data_o,
    output logic [LAYER_SELECT_BITS+RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] w_addr_o,
    output logic                                                         start_o,
    output logic                                                         loaded_o,
    output logic                                                         err_o
);

    // state     | meaning
    // S_IDLE    | nothing loaded yet (or reset), waiting for load_i
    // S_LOAD    | accepting parameter words, one per transfer
    // S_LOADED  | every RAM written, start_i may launch inference
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_LOADED = 2'd2
    } state_t;

    localparam int AW = LAYER_SELECT_BITS + RAM_SELECT_BITS + RAM_ADDRESS_BITS;

    localparam logic [LAYER_SELECT_BITS-1:0] LYR0 = LAYER_SELECT_BITS'(0);
    localparam logic [LAYER_SELECT_BITS-1:0] LYR1 = LAYER_SELECT_BITS'(1);
    localparam logic [LAYER_SELECT_BITS-1:0] LYR2 = LAYER_SELECT_BITS'(2);
    localparam logic [LAYER_SELECT_BITS-1:0] LYR3 = LAYER_SELECT_BITS'(3);

    state_t                         state_q, state_d;
    logic [LAYER_SELECT_BITS-1:0]   layer_q, layer_d;
    logic [RAM_SELECT_BITS-1:0]     ram_q, ram_d;
    logic [RAM_ADDRESS_BITS-1:0]    addr_q, addr_d;
    logic                           w_en_q, w_en_d;
    logic [MEM_WORD_SIZE-1:0]       w_data_q, w_data_d;
    logic [AW-1:0]                  w_addr_q, w_addr_d;
    logic                           start_q, start_d;
    logic                           err_q, err_d;

    logic                           xfer;
    logic                           addr_last;
    logic                           ram_last;
    logic                           last_word;

    // Terminal counts depend on which layer is currently being filled.
    always_comb begin
        addr_last = 1'b0;
        ram_last  = 1'b0;
        case (layer_q)
            LYR0: begin
                addr_last = (addr_q == RAM_ADDRESS_BITS'(L0_DEPTH - 1));
                ram_last  = (ram_q  == RAM_SELECT_BITS'(L0_RAMS - 1));
            end
            LYR1: begin
                addr_last = (addr_q == RAM_ADDRESS_BITS'(L1_DEPTH - 1));
                ram_last  = (ram_q  == RAM_SELECT_BITS'(L1_RAMS - 1));
            end
            LYR2: begin
                addr_last = (addr_q == RAM_ADDRESS_BITS'(L2_DEPTH - 1));
                ram_last  = (ram_q  == RAM_SELECT_BITS'(L2_RAMS - 1));
            end
            LYR3: begin
                addr_last = (addr_q == RAM_ADDRESS_BITS'(L3_DEPTH - 1));
                ram_last  = (ram_q  == RAM_SELECT_BITS'(L3_RAMS - 1));
            end
            default: begin
                addr_last = 1'b1;
                ram_last  = 1'b1;
            end
        endcase
    end

    assign xfer      = valid_i && (state_q == S_LOAD);
    assign last_word = (layer_q == LYR3) && ram_last && addr_last;

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        ram_d    = ram_q;
        addr_d   = addr_q;
        start_d  = 1'b0;
        err_d    = err_q;
        w_en_d   = xfer;
        w_data_d = w_data_q;
        w_addr_d = w_addr_q;

        if (xfer) begin
            w_data_d = data_i;
            w_addr_d = {layer_q, ram_q, addr_q};
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b1;
                end
                if (load_i) begin
                    state_d = S_LOAD;
                    layer_d = '0;
                    ram_d   = '0;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                if (start_i) begin
                    err_d = 1'b1;
                end
                if (xfer) begin
                    if (last_word) begin
                        state_d = S_LOADED;
                        layer_d = '0;
                        ram_d   = '0;
                        addr_d  = '0;
                    end else if (addr_last) begin
                        addr_d = '0;
                        if (ram_last) begin
                            ram_d   = '0;
                            layer_d = layer_q + 1'b1;
                        end else begin
                            ram_d = ram_q + 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_LOADED: begin
                // start wins over a simultaneous reload request
                if (!net_busy_i) begin
                    if (start_i) begin
                        start_d = 1'b1;
                    end else if (load_i) begin
                        state_d = S_LOAD;
                        layer_d = '0;
                        ram_d   = '0;
                        addr_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            ram_q    <= '0;
            addr_q   <= '0;
            w_en_q   <= 1'b0;
            w_data_q <= '0;
            w_addr_q <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            ram_q    <= ram_d;
            addr_q   <= addr_d;
            w_en_q   <= w_en_d;
            w_data_q <= w_data_d;
            w_addr_q <= w_addr_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

    assign ready_o  = (state_q == S_LOAD);
    assign loaded_o = (state_q == S_LOADED);
    assign w_en_o   = w_en_q;
    assign w_data_o = w_data_q;
    assign w_addr_o = w_addr_q;
    assign start_o  = start_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl on a 16-word configuration; expected writes come
// from a list of {layer, ram, addr} built by plain nested loops.
module tb_weight_load_ctrl;

    localparam int MW = 21;
    localparam int LB = 2;
    localparam int RB = 8;
    localparam int AB = 9;
    localparam int AW = LB + RB + AB;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          load_i = 1'b0;
    logic          net_busy_i = 1'b0;
    logic          start_i = 1'b0;
    logic [MW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          w_en_o;
    logic [MW-1:0] w_data_o;
    logic [AW-1:0] w_addr_o;
    logic          start_o;
    logic          loaded_o;
    logic          err_o;

    weight_load_ctrl #(
        .MEM_WORD_SIZE(MW), .LAYER_SELECT_BITS(LB), .RAM_SELECT_BITS(RB),
        .RAM_ADDRESS_BITS(AB),
        .L0_RAMS(2), .L0_DEPTH(3), .L1_RAMS(2), .L1_DEPTH(3),
        .L2_RAMS(1), .L2_DEPTH(2), .L3_RAMS(1), .L3_DEPTH(2)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .load_i(load_i), .net_busy_i(net_busy_i),
        .start_i(start_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .w_en_o(w_en_o), .w_data_o(w_data_o), .w_addr_o(w_addr_o),
        .start_o(start_o), .loaded_o(loaded_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_addr[$];
    logic          err_exp = 1'b0;
    int            lrams[4] = '{2, 2, 1, 1};
    int            ldep[4]  = '{3, 3, 2, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_ready",  32'(ready_o),  32'd0);
        check("rst_w_en",   32'(w_en_o),   32'd0);
        check("rst_w_data", 32'(w_data_o), 32'd0);
        check("rst_w_addr", 32'(w_addr_o), 32'd0);
        check("rst_start",  32'(start_o),  32'd0);
        check("rst_loaded", 32'(loaded_o), 32'd0);
        check("rst_err",    32'(err_o),    32'd0);
    endtask

    task automatic check_loaded_idle();
        check("post_ready",  32'(ready_o),  32'd0);
        check("post_loaded", 32'(loaded_o), 32'd1);
        check("post_w_en",   32'(w_en_o),   32'd0);
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid/data
    // plus random start_i/load_i pulses during the load.
    task automatic run_load(input int mode, input int limit, input int start_at);
        int            idx = 0;
        int            budget = 0;
        bit            pend = 1'b0;
        bit            active;
        bit            v;
        logic [AW-1:0] pa = '0;
        logic [MW-1:0] pd = '0;
        logic [MW-1:0] d;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        while ((idx < limit || pend) && budget < 400) begin
            check("ready",   32'(ready_o),  32'(idx < N));
            check("loaded",  32'(loaded_o), 32'(idx == N));
            check("start_o", 32'(start_o),  32'd0);
            check("err",     32'(err_o),    32'(err_exp));
            check("w_en",    32'(w_en_o),   32'(pend));
            if (pend) begin
                check("w_data", 32'(w_data_o), 32'(pd));
                check("w_addr", 32'(w_addr_o), 32'(pa));
            end
            active = (idx < limit);
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 2) ? MW'($urandom) : MW'(idx + 1);
            valid_i = active ? v : (mode == 0 && limit == N);
            data_i  = d;
            start_i = active && ((idx == start_at) || (mode == 2 && $urandom_range(0, 7) == 0));
            load_i  = active && mode == 2 && $urandom_range(0, 7) == 0;
            if (start_i) err_exp = 1'b1;
            if (valid_i && idx < N) begin
                pend = 1'b1;
                pa   = exp_addr[idx];
                pd   = d;
                idx++;
            end else begin
                pend = 1'b0;
            end
            step();
            budget++;
        end
        check("words_done", 32'(idx), 32'(limit));
        valid_i = 1'b0;
        start_i = 1'b0;
        load_i  = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < lrams[l]; r++)
                for (int a = 0; a < ldep[l]; a++)
                    exp_addr.push_back({2'(l), 8'(r), 9'(a)});

        check("list_w1",  32'(exp_addr[0]),  32'({2'd0, 8'd0, 9'd0}));
        check("list_w4",  32'(exp_addr[3]),  32'({2'd0, 8'd1, 9'd0}));
        check("list_w7",  32'(exp_addr[6]),  32'({2'd1, 8'd0, 9'd0}));
        check("list_w16", 32'(exp_addr[15]), 32'({2'd3, 8'd0, 9'd1}));

        reset_i = 1'b1;
        step();
        step();
        check_reset_vals();
        reset_i = 1'b0;
        step();

        // start before any load: flagged as error, no pulse
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        err_exp = 1'b1;
        check("idle_start_o", 32'(start_o), 32'd0);
        check("idle_err",     32'(err_o),   32'd1);
        check("idle_ready",   32'(ready_o), 32'd0);

        run_load(0, N, 5);
        check_loaded_idle();

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("start_pulse",   32'(start_o), 32'd1);
        check("start_err",     32'(err_o),   32'd1);
        step();
        check("start_one_cyc", 32'(start_o), 32'd0);

        // busy datapath ignores both load and start
        net_busy_i = 1'b1;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        check("busy_ready",  32'(ready_o),  32'd0);
        check("busy_loaded", 32'(loaded_o), 32'd1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_start_o", 32'(start_o), 32'd0);
        check("busy_err",     32'(err_o),   32'd1);
        step();
        check("busy_ready2",  32'(ready_o), 32'd0);
        net_busy_i = 1'b0;

        load_i = 1'b1;
        start_i = 1'b1;
        step();
        load_i = 1'b0;
        start_i = 1'b0;
        check("ls_start_o", 32'(start_o),  32'd1);
        check("ls_ready",   32'(ready_o),  32'd0);
        check("ls_loaded",  32'(loaded_o), 32'd1);
        step();
        check("ls_ready2",  32'(ready_o),  32'd0);
        check("ls_start2",  32'(start_o),  32'd0);

        run_load(1, N, -1);
        check_loaded_idle();

        for (int k = 0; k < 4; k++) begin
            run_load(2, N, -1);
            check_loaded_idle();
        end

        // reset partway through a load, then reload from scratch
        run_load(0, 5, -1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        err_exp = 1'b0;
        check_reset_vals();
        step();
        check("after_rst_ready",  32'(ready_o),  32'd0);
        check("after_rst_loaded", 32'(loaded_o), 32'd0);
        run_load(0, N, -1);
        check_loaded_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
